// File: rtl/dmem_responder_pkg.sv
// Shared widths, funct3 load/store codes, byte-enable patterns and FSM state type
// for the data-memory responder.
package dmem_responder_pkg;

    localparam int XLEN   = 32;
    localparam int NBYTES = XLEN / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [NBYTES-1:0] BE_BYTE = 4'b0001;
    localparam logic [NBYTES-1:0] BE_HALF = 4'b0011;
    localparam logic [NBYTES-1:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables and replicated write lanes,
// load lane selection with sign/zero extension, plus alignment and mode legality.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic              write,
    input  logic [2:0]        mode,
    input  logic [1:0]        addr_lo,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rword,
    output logic [NBYTES-1:0] byte_en,
    output logic [XLEN-1:0]   wlanes,
    output logic [XLEN-1:0]   rdata_ext,
    output logic              misalign,
    output logic              bad_mode
);

    logic [XLEN-1:0] rshift;

    assign rshift = rword >> {addr_lo, 3'b000};

    always_comb begin
        byte_en   = '0;
        wlanes    = '0;
        rdata_ext = '0;
        misalign  = 1'b0;
        bad_mode  = 1'b0;
        case (mode)
            F3_B, F3_BU: begin
                byte_en   = BE_BYTE << addr_lo;
                wlanes    = {NBYTES{wdata[7:0]}};
                rdata_ext = (mode == F3_B) ? {{(XLEN-8){rshift[7]}}, rshift[7:0]}
                                           : {{(XLEN-8){1'b0}}, rshift[7:0]};
            end
            F3_H, F3_HU: begin
                misalign  = addr_lo[0];
                byte_en   = BE_HALF << {addr_lo[1], 1'b0};
                wlanes    = {(NBYTES/2){wdata[15:0]}};
                rdata_ext = (mode == F3_H) ? {{(XLEN-16){rshift[15]}}, rshift[15:0]}
                                           : {{(XLEN-16){1'b0}}, rshift[15:0]};
            end
            F3_W: begin
                misalign  = |addr_lo;
                byte_en   = BE_WORD;
                wlanes    = wdata;
                rdata_ext = rshift;
            end
            default: bad_mode = 1'b1;
        endcase
        // Unsigned variants exist only for loads.
        if (write && mode[2]) begin
            bad_mode = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Target-side data memory for the MEM stage: one request at a time, LATENCY-cycle
// access to an internal word SRAM, with fault reporting on bad mode/alignment/range.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int              DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0,
    parameter int              LATENCY     = 1
) (
    input  logic            clk,
    input  logic            pc_rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_mode,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            busy,
    output state_e          fsm_state
);

    localparam int              AW       = $clog2(DEPTH_WORDS);
    localparam int              CW       = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0]   CNT_INIT = CW'((LATENCY >= 2) ? LATENCY - 2 : 0);
    localparam logic [XLEN-1:0] SPAN     = XLEN'(DEPTH_WORDS * NBYTES);

    state_e            state, state_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic              cap_write;
    logic [2:0]        cap_mode;
    logic [XLEN-1:0]   cap_addr, cap_wdata;
    logic              op_write;
    logic [2:0]        op_mode;
    logic [XLEN-1:0]   op_addr, op_wdata;
    logic              accept, enter_resp, mem_we;
    logic [XLEN:0]     diff;
    logic [XLEN-1:0]   off;
    logic              range_bad, fault;
    logic [AW-1:0]     idx;
    logic [XLEN-1:0]   rword, wlanes, rdata_ext;
    logic [NBYTES-1:0] byte_en;
    logic              misalign, bad_mode;
    logic [XLEN-1:0]   mem [DEPTH_WORDS];

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is registered, high only in IDLE, and req_* are don't-care otherwise.
    assign accept    = req_valid && req_ready;
    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

    // A LATENCY==1 access happens on the accept edge itself, so idle uses the live request.
    assign op_write = (state == ST_IDLE) ? req_write : cap_write;
    assign op_mode  = (state == ST_IDLE) ? req_mode  : cap_mode;
    assign op_addr  = (state == ST_IDLE) ? req_addr  : cap_addr;
    assign op_wdata = (state == ST_IDLE) ? req_wdata : cap_wdata;

    assign diff      = {1'b0, op_addr} - {1'b0, BASE_ADDR};
    assign off       = diff[XLEN-1:0];
    assign range_bad = diff[XLEN] || (off >= SPAN);
    assign idx       = off[AW+1:2];
    assign rword     = mem[idx];
    assign fault     = range_bad | misalign | bad_mode;

    dmem_lane_align u_align (
        .write     (op_write),
        .mode      (op_mode),
        .addr_lo   (op_addr[1:0]),
        .wdata     (op_wdata),
        .rword     (rword),
        .byte_en   (byte_en),
        .wlanes    (wlanes),
        .rdata_ext (rdata_ext),
        .misalign  (misalign),
        .bad_mode  (bad_mode)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) state_next = ST_RESP;
                else           cnt_next   = cnt - 1'b1;
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign enter_resp = (state_next == ST_RESP);
    assign mem_we     = enter_resp && op_write && !fault && pc_rst_n;

    always_ff @(posedge clk or negedge pc_rst_n) begin
        if (!pc_rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cap_write <= 1'b0;
            cap_mode  <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                cap_write <= req_write;
                cap_mode  <= req_mode;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
            req_ready <= (state_next == ST_IDLE);
            rsp_valid <= enter_resp;
            rsp_err   <= enter_resp && fault;
            rsp_rdata <= (enter_resp && !fault && !op_write) ? rdata_ext : '0;
        end
    end

    // SRAM contents survive reset; writes commit on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

endmodule
